// File: rtl/in_port_reader.sv
// Purpose: synchronise, debounce and hold the TD4 input switches for the IN instruction.
// Latency: a clean step on raw_in reaches data at the (DEBOUNCE_CYCLES+3)th edge.
// Backpressure: none; en=0 freezes the debouncer, and rd clears the sticky changed flag.
module in_port_reader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             changed
);

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync_q;

    // The synchroniser keeps sampling while en=0 so resumption sees the current inputs.
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
        end
    end

    assign sync_q = sync2;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= STABLE;
            cnt     <= '0;
            cand    <= '0;
            data    <= '0;
            changed <= 1'b0;
        end else if (en) begin
            if (rd) begin
                changed <= 1'b0;
            end
            case (state)
                STABLE: begin
                    if (sync_q != data) begin
                        state <= SETTLE;
                        cand  <= sync_q;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (sync_q == data) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (sync_q != cand) begin
                        cand <= sync_q;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Later assignment overrides a same-edge rd: new data wins.
                        data    <= cand;
                        changed <= 1'b1;
                        state   <= STABLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign valid = (state == STABLE);

endmodule

// File: tb/tb_in_port_reader.sv
module tb_in_port_reader;

    logic       clk;
    logic       clr;
    logic       en;
    logic [3:0] raw_in;
    logic       rd;
    logic [3:0] data;
    logic       valid;
    logic       changed;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [3:0] prev_data = 4'h0;

    in_port_reader #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .en(en),
        .raw_in(raw_in),
        .rd(rd),
        .data(data),
        .valid(valid),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: a commit is a change of data together with changed set.
    always @(posedge clk) begin
        #1;
        if (data !== prev_data && changed === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_commit", {28'h0, data}, {28'h0, prev_data});
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data", {28'h0, data}, {28'h0, e.val});
                check("sb_edge", cyc, e.cyc);
            end
        end
        prev_data = data;
    end

    // Expected commit edge for a clean step driven just after the current edge.
    task automatic expect_commit(input logic [3:0] v, input int after);
        exp_t e;
        e.val = v;
        e.cyc = cyc + after;
        sb.push_back(e);
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    initial begin
        clr    = 1'b0;
        en     = 1'b1;
        raw_in = 4'b1010;
        rd     = 1'b0;

        // Reset held for two edges
        step(1);
        check("rst_valid_e1", valid, 1);
        step(1);
        check("rst_data", data, 0);
        check("rst_changed", changed, 0);
        check("rst_valid_e2", valid, 1);

        clr    = 1'b1;
        raw_in = 4'h0;
        step(3);
        check("idle_valid", valid, 1);

        // Clean step to 3
        raw_in = 4'h3;
        expect_commit(4'h3, 7);
        step(2);
        check("step_valid_e2", valid, 1);
        step(1);
        check("step_valid_e3", valid, 0);
        step(3);
        check("step_data_e6", data, 0);
        check("step_valid_e6", valid, 0);
        step(1);
        check("step_data_e7", data, 3);
        check("step_changed_e7", changed, 1);
        check("step_valid_e7", valid, 1);
        read_pulse();
        check("rd_clears", changed, 0);
        check("rd_keeps_data", data, 3);

        // Return to 0 for the bounce test
        raw_in = 4'h0;
        expect_commit(4'h0, 7);
        step(7);
        read_pulse();
        check("zero_changed", changed, 0);

        // Short glitch to 5 bounces back
        raw_in = 4'h5;
        step(2);
        raw_in = 4'h0;
        step(1);
        check("glitch_valid_settle", valid, 0);
        step(3);
        check("glitch_valid_back", valid, 1);
        check("glitch_data", data, 0);
        check("glitch_changed", changed, 0);

        // 5/6 toggling every 2 cycles never commits
        for (int k = 0; k < 6; k++) begin
            raw_in = (k % 2 == 0) ? 4'h5 : 4'h6;
            step(2);
        end
        check("toggle_valid", valid, 0);
        check("toggle_data", data, 0);
        check("toggle_changed", changed, 0);
        raw_in = 4'h5;
        expect_commit(4'h5, 7);
        step(6);
        check("toggle_hold_e6", data, 0);
        step(1);
        check("toggle_commit", data, 5);
        read_pulse();

        // rd on the commit edge: new data wins
        raw_in = 4'h9;
        expect_commit(4'h9, 7);
        step(6);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        check("coll_data", data, 9);
        check("coll_changed", changed, 1);

        // Freeze mid-settle; rd with en=0 must be ignored
        raw_in = 4'hC;
        expect_commit(4'hC, 17);
        step(4);
        en = 1'b0;
        step(4);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        step(5);
        check("frz_data", data, 9);
        check("frz_changed", changed, 1);
        check("frz_valid", valid, 0);
        en = 1'b1;
        step(2);
        check("frz_resume_e2", data, 9);
        step(1);
        check("frz_commit", data, 4'hC);
        read_pulse();
        check("frz_rd_clear", changed, 0);

        // Reset while settling on 4'hF
        raw_in = 4'hF;
        step(4);
        check("mid_valid", valid, 0);
        clr = 1'b0;
        step(1);
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", valid, 1);
        check("mid_rst_changed", changed, 0);
        clr = 1'b1;
        expect_commit(4'hF, 7);
        step(6);
        check("mid_hold_e6", data, 0);
        step(1);
        check("mid_commit_changed", changed, 1);

        step(3);
        check("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
